// File: rtl/ps2_host_tx_if.sv
// Byte-send handshake between the control logic and the PS/2 host transmitter.
//
// Handshake: the master holds tx_valid and tx_data steady while it waits. A
// transfer is accepted on a clock edge where tx_valid & tx_ready are both
// high. tx_ready is high only while the transmitter is idle. tx_busy is
// always ~tx_ready. tx_done and tx_error are single-cycle result pulses.
// tx_state mirrors the transmitter FSM for observation only.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;
   logic [2:0] tx_state;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_busy, tx_done, tx_error, tx_state
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_busy, tx_done, tx_error, tx_state
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, serialise
// start/data/parity/stop bits on device clock falling edges, check the ack.
// Optional watchdog enabled with the macro PS2_TX_TIMEOUT_EN.

// Two-flop synchroniser for an asynchronous pad; idles high like the bus.
module synchronize (
   input  logic clk_in,
   input  logic reset_in,
   input  logic async_in,
   output logic sync_out
);
   logic meta_q;
   logic sync_q;

   // Shift the pad level through two flops.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
      end
   end

   assign sync_out = sync_q;
endmodule

// Accepts a new level only after it has been stable for CYCLES cycles.
module debounce #(
   parameter int CYCLES = 743
) (
   input  logic clk_in,
   input  logic reset_in,
   input  logic level_in,
   output logic level_out
);
   localparam int CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LIM = CW'(CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic          level_q;

   // Count cycles of disagreement; adopt the input once the count expires.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         cnt_q   <= '0;
         level_q <= 1'b1;
      end else if (level_in == level_q) begin
         cnt_q <= '0;
      end else if (cnt_q == LIM) begin
         cnt_q   <= '0;
         level_q <= level_in;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign level_out = level_q;
endmodule

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES  = 14850,
   parameter int SETUP_CYCLES    = 743,
   parameter int DEBOUNCE_CYCLES = 743,
   parameter int TIMEOUT_CYCLES  = 2227500
) (
   input  logic               clk_in,
   input  logic               reset_in,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   ps2_host_tx_if.slave       tx,
   output logic               ps2_clk_drive_low,
   output logic               ps2_data_drive_low
);
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_REQUEST   = 3'd2;
   localparam logic [2:0] S_SEND      = 3'd3;
   localparam logic [2:0] S_ACK       = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

   localparam logic [21:0] INHIBIT_LIM = 22'(INHIBIT_CYCLES - 1);
   localparam logic [21:0] SETUP_LIM   = 22'(SETUP_CYCLES - 1);
   localparam logic [21:0] TIMEOUT_LIM = 22'(TIMEOUT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif

   logic       clk_sync, data_sync;
   logic       db_clk, db_data;
   logic       fall;

   logic [2:0]  state_q, state_d;
   logic [21:0] tmr_q, tmr_d;         // phase timer, then watchdog once in SEND
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [9:0]  frame_q, frame_d;
   logic        clk_low_q, clk_low_d;
   logic        data_low_q, data_low_d;
   logic        ack_ok_q, ack_ok_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        db_clk_prev_q;
   logic        watched;

   synchronize u_sync_clk  (.clk_in(clk_in), .reset_in(reset_in), .async_in(ps2_clk),  .sync_out(clk_sync));
   synchronize u_sync_data (.clk_in(clk_in), .reset_in(reset_in), .async_in(ps2_data), .sync_out(data_sync));
   debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clk  (.clk_in(clk_in), .reset_in(reset_in), .level_in(clk_sync),  .level_out(db_clk));
   debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_data (.clk_in(clk_in), .reset_in(reset_in), .level_in(data_sync), .level_out(db_data));

   // Only device-driven falling edges advance the frame.
   assign fall    = db_clk_prev_q & ~db_clk;
   assign watched = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

   // Next-state logic for the transfer sequence and optional watchdog.
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      bit_cnt_d  = bit_cnt_q;
      frame_d    = frame_q;
      clk_low_d  = clk_low_q;
      data_low_d = data_low_q;
      ack_ok_d   = ack_ok_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
            if (tx.tx_valid) begin
               frame_d   = {1'b1, ~^tx.tx_data, tx.tx_data};
               bit_cnt_d = 4'd0;
               tmr_d     = '0;
               clk_low_d = 1'b1;
               state_d   = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (tmr_q == INHIBIT_LIM) begin
               tmr_d      = '0;
               data_low_d = 1'b1;
               state_d    = S_REQUEST;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_REQUEST: begin
            if (tmr_q == SETUP_LIM) begin
               tmr_d     = '0;
               clk_low_d = 1'b0;
               state_d   = S_SEND;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_SEND: begin
            if (fall) begin
               data_low_d = ~frame_q[bit_cnt_q];
               if (bit_cnt_q == 4'd9) state_d = S_ACK;
               else                   bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_ACK: begin
            if (fall) begin
               ack_ok_d = ~db_data;
               state_d  = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (db_clk && db_data) begin
               done_d  = ack_ok_q;
               error_d = ~ack_ok_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Watchdog: a completion in the same cycle takes priority.
      if (WDOG_EN && watched && (state_d != S_IDLE)) begin
         if (tmr_q == TIMEOUT_LIM) begin
            state_d    = S_IDLE;
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
            error_d    = 1'b1;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q       <= S_IDLE;
         tmr_q         <= '0;
         bit_cnt_q     <= 4'd0;
         frame_q       <= '0;
         clk_low_q     <= 1'b0;
         data_low_q    <= 1'b0;
         ack_ok_q      <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         db_clk_prev_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         bit_cnt_q     <= bit_cnt_d;
         frame_q       <= frame_d;
         clk_low_q     <= clk_low_d;
         data_low_q    <= data_low_d;
         ack_ok_q      <= ack_ok_d;
         done_q        <= done_d;
         error_q       <= error_d;
         db_clk_prev_q <= db_clk;
      end
   end

   assign tx.tx_ready         = (state_q == S_IDLE);
   assign tx.tx_busy          = (state_q != S_IDLE);
   assign tx.tx_done          = done_q;
   assign tx.tx_error         = error_q;
   assign tx.tx_state         = state_q;
   assign ps2_clk_drive_low   = clk_low_q;
   assign ps2_data_drive_low  = data_low_q;
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: takes one byte from the game/control logic and sends it to the keyboard over the shared open-drain PS/2 clock and data lines, e.g. LED-set (0xED) or reset (0xFF) commands. It runs the full host request sequence, serialises start, data, odd-parity and stop bits on device-generated clock edges, and checks the device acknowledge. It sits beside the PS/2 receiver at the input layer. The top level uses `tx_busy` to gate the receiver while a transfer is in flight, and turns the two drive-low outputs into tristate pads.

## Interface
- `INHIBIT_CYCLES`, 14850: clock-low inhibit hold, 100 us at 148.5 MHz.
- `SETUP_CYCLES`, 743: data-low setup before clock release, 5 us.
- `DEBOUNCE_CYCLES`, 743: passed to the internal `debounce` instances.
- `TIMEOUT_CYCLES`, 2227500: watchdog limit, 15 ms. Used only with `PS2_TX_TIMEOUT_EN`.
- `clk_in` input 1: system clock. This is the only clock.
- `reset_in` input 1: synchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock pad. Goes through `synchronize` and then `debounce`.
- `ps2_data` input 1: raw PS/2 data pad. Goes through `synchronize` and then `debounce`.
- `tx_data` input 8: byte to send. Captured on accept.
- `tx_valid` input 1: a send is requested.
- `tx_ready` output 1: high only in IDLE. A transfer is accepted when `tx_valid & tx_ready`.
- `tx_busy` output 1: equals `~tx_ready`.
- `tx_done` output 1: one-cycle pulse when the device acknowledged the byte.
- `tx_error` output 1: one-cycle pulse on a missing ack or a timeout.
- `ps2_clk_drive_low` output 1: 1 means pull the clock pad low; 0 means release it.
- `ps2_data_drive_low` output 1: 1 means pull the data pad low; 0 means release it.

## Operation
- Frame shift register: {stop=1, parity=~^tx_data, tx_data[7:0]}. Bits go out LSB first. Bit counter runs 0..9.
- IDLE:
  - Both drive-lows are 0.
  - On accept: latch the frame, clear the counter, go to INHIBIT.
- INHIBIT:
  - `ps2_clk_drive_low`=1.
  - After INHIBIT_CYCLES cycles, go to REQUEST.
- REQUEST:
  - Clock and data are both driven low.
  - After SETUP_CYCLES cycles, go to SEND. `ps2_clk_drive_low` drops to 0 on entry to SEND.
- SEND:
  - Data stays low (start bit) until the first falling edge of the debounced clock.
  - Falling edge = previous debounced clk 1 and current 0.
  - On each falling edge: `ps2_data_drive_low` <= ~frame[cnt], then cnt++.
  - After the falling edge with cnt=9, the stop bit is presented (data released). Go to ACK.
- ACK:
  - On the next falling edge, sample debounced data.
  - Data 0: ack is good. Data 1: ack failed. Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until debounced clk=1 and data=1.
  - Then pulse `tx_done` on a good ack, or `tx_error` on a failed ack, and go to IDLE.
- Rising edges never change state. The host only changes data while the device holds the clock low.
- `tx_valid` outside IDLE is ignored. `tx_data` is not re-sampled mid-frame.
- Reset mid-transfer: on the cycle after `reset_in` is high, both lines are released, the state is IDLE and no pulse is issued.

## Timing
- Reset values:
  - state IDLE.
  - `tx_ready`=1, `tx_busy`=0.
  - `tx_done`=0, `tx_error`=0.
  - Both drive-lows 0.
  - Edge-detect history = 1.
- Accept at cycle N: `ps2_clk_drive_low`=1 at N+1.
- `ps2_data_drive_low`=1 at N+1+INHIBIT_CYCLES.
- Clock released at N+1+INHIBIT_CYCLES+SETUP_CYCLES.
- Data response: the new data level appears one cycle after the debounced falling edge, which is DEBOUNCE_CYCLES+2 after the pad edge. This is well inside the ≥30 us device low phase.
- `tx_done`/`tx_error` are registered, exactly one cycle wide. `tx_ready` rises in the same cycle as the pulse.
- Minimum gap between transfers: 1 cycle (accept can happen in the cycle `tx_ready` first returns).

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A 22-bit watchdog is cleared on entry to SEND and counts every cycle in SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse `tx_error`, return to IDLE in the next cycle.
  - A simultaneous completion wins over the timeout.
- Not defined: no watchdog. A silent device leaves the block in SEND/ACK/WAIT_IDLE until reset.

## Test plan
- Send 0xED to a device model that clocks at 80 us period and acks:
  - Line bits after start are 1,0,1,1,0,1,1,1, then parity 1, then stop released.
  - Clock is held low for ≥100 us before release.
  - Exactly one `tx_done`; `tx_error` never rises.
- Send 0xF4:
  - Parity bit 0.
  - `tx_done` pulses once.
  - `tx_ready` is 0 for the whole frame and 1 in the pulse cycle.
- Device model omits the ack (data high on the 11th clock):
  - `tx_error` pulses once, no `tx_done`.
  - Block returns to IDLE after the lines go idle.
- Assert `tx_valid` with 0x55 during a 0xFF transfer, then deassert it:
  - The line frame is 0xFF with parity 1.
  - 0x55 is never sent.
- Assert `reset_in` for one cycle at data bit 4:
  - Both drive-lows are 0 and `tx_ready`=1 on the next cycle.
  - Then send 0xED cleanly.
- With `PS2_TX_TIMEOUT_EN` and TIMEOUT_CYCLES=1000, device never clocks:
  - `tx_error` pulses 1000 cycles after clock release, then IDLE.
- Without `PS2_TX_TIMEOUT_EN`, same device:
  - Still in SEND after 10× that time, and no pulse.
